// File: rtl/stack_alu.sv
// Stack ALU: 1-cycle R1/R2/ADD/SUB/MUL, WIDTH-cycle restoring DIV, valid/ready on both sides.
// A held result (out_valid && !out_ready) blocks new requests and freezes every output.
module stack_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic             div_zero,
    output logic             bad_func
);

    typedef enum logic {S_IDLE, S_DIV} state_t;

    localparam logic [3:0] F_R1  = 4'd0;
    localparam logic [3:0] F_R2  = 4'd1;
    localparam logic [3:0] F_ADD = 4'd2;
    localparam logic [3:0] F_SUB = 4'd3;
    localparam logic [3:0] F_MUL = 4'd4;
    localparam logic [3:0] F_DIV = 4'd5;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] o0_q, o0_d;
    logic [WIDTH-1:0] o1_q, o1_d;
    logic             div_zero_q, div_zero_d;
    logic             bad_func_q, bad_func_d;

    logic             accept;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            out_valid_q <= 1'b0;
            o0_q        <= '0;
            o1_q        <= '0;
            div_zero_q  <= 1'b0;
            bad_func_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            out_valid_q <= out_valid_d;
            o0_q        <= o0_d;
            o1_q        <= o1_d;
            div_zero_q  <= div_zero_d;
            bad_func_q  <= bad_func_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && func == F_DIV && i1 != '0) state_d = S_DIV;
            S_DIV:  if (cnt_q == CNT_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
        accept    = in_valid && in_ready;
        out_valid = out_valid_q;
        o0        = o0_q;
        o1        = o1_q;
        div_zero  = div_zero_q;
        bad_func  = bad_func_q;
    end

    assign prod = {{WIDTH{1'b0}}, i0} * {{WIDTH{1'b0}}, i1};

    // Partial remainder stays below the divisor, so no borrow out of bit WIDTH means trial >= divisor.
    assign trial  = {rem_q, quo_q[WIDTH-1]};
    assign diff   = trial - {1'b0, dvs_q};
    assign q_bit  = !diff[WIDTH];
    assign rem_nx = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_nx = {quo_q[WIDTH-2:0], q_bit};

    always_comb begin
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        out_valid_d = out_valid_q;
        o0_d        = o0_q;
        o1_d        = o1_q;
        div_zero_d  = div_zero_q;
        bad_func_d  = bad_func_q;
        if (accept) begin
            out_valid_d = 1'b1;
            o1_d        = '0;
            div_zero_d  = 1'b0;
            bad_func_d  = 1'b0;
            case (func)
                F_R1:  o0_d = i0;
                F_R2:  o0_d = i1;
                F_ADD: o0_d = i0 + i1;
                F_SUB: o0_d = i0 - i1;
                F_MUL: begin
                    o0_d = prod[WIDTH-1:0];
                    o1_d = prod[2*WIDTH-1:WIDTH];
                end
                F_DIV: begin
                    if (i1 == '0) begin
                        o0_d       = '1;
                        o1_d       = i0;
                        div_zero_d = 1'b1;
                    end else begin
                        // Old result registers stay untouched until the quotient is ready.
                        out_valid_d = 1'b0;
                        o0_d        = o0_q;
                        o1_d        = o1_q;
                        div_zero_d  = div_zero_q;
                        bad_func_d  = bad_func_q;
                        quo_d       = i0;
                        rem_d       = '0;
                        dvs_d       = i1;
                        cnt_d       = '0;
                    end
                end
                default: begin
                    o0_d       = '0;
                    bad_func_d = 1'b1;
                end
            endcase
        end else if (state_q == S_DIV) begin
            quo_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                out_valid_d = 1'b1;
                o0_d        = quo_nx;
                o1_d        = rem_nx;
                div_zero_d  = 1'b0;
                bad_func_d  = 1'b0;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

endmodule
